// File: rtl/kernel_monitor_pkg.sv
// Shared definitions for the EQ kernel monitor.
//   kmon_state_t      : stall detector state encoding.
//   STALL_CNT_W       : width of the stall/consecutive-cycle counters.
//   DEFAULT_THRESHOLD : default number of stable-stall cycles before a block.
package kernel_monitor_pkg;

    localparam int unsigned STALL_CNT_W       = 16;
    localparam int unsigned DEFAULT_THRESHOLD = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        BLOCKED = 2'd2
    } kmon_state_t;

endpackage

// File: rtl/stall_sat_counter.sv
// Saturating up-counter used for both the consecutive-cycle counter and the
// reported stall length.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to 0 (highest priority)
//   i_load1    : synchronous load of 1
//   i_inc      : increment, holding at all-ones
//   o_count    : current count
module stall_sat_counter
    import kernel_monitor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_load1,
    input  logic                   i_inc,
    output logic [STALL_CNT_W-1:0] o_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_load1) begin
            o_count <= STALL_CNT_W'(1);
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: rtl/kernel_stall_detector.sv
// Kernel stall detector: declares a block once a stable, non-idle stall
// pattern persists for THRESHOLD consecutive cycles.
//   kernel_monitor_clock : sole clock
//   kernel_monitor_reset : asynchronous active-low reset
//   axis_block_sigs      : per-channel stream blocked flags
//   inst_idle_sigs       : per-instance idle flags
//   inst_block_sigs      : per-instance blocked flags
//   clear                : synchronous release of a block, zeroes counters
//   block                : kernel declared blocked
//   block_pulse          : one-cycle strobe on entry to BLOCKED
//   block_cause          : {inst_block_sigs, axis_block_sigs} at entry
//   stall_cycles         : length of current stable stall (saturating)
//   block_events         : number of entries to BLOCKED (wrapping)
module kernel_stall_detector
    import kernel_monitor_pkg::*;
#(
    parameter int unsigned N_AXIS    = 2,
    parameter int unsigned N_IDLE    = 3,
    parameter int unsigned N_BLK     = 1,
    parameter int unsigned THRESHOLD = DEFAULT_THRESHOLD,
    parameter int unsigned EVT_W     = 8
) (
    input  logic                    kernel_monitor_clock,
    input  logic                    kernel_monitor_reset,
    input  logic [N_AXIS-1:0]       axis_block_sigs,
    input  logic [N_IDLE-1:0]       inst_idle_sigs,
    input  logic [N_BLK-1:0]        inst_block_sigs,
    input  logic                    clear,
    output logic                    block,
    output logic                    block_pulse,
    output logic [N_AXIS+N_BLK-1:0] block_cause,
    output logic [STALL_CNT_W-1:0]  stall_cycles,
    output logic [EVT_W-1:0]        block_events
);

    localparam int unsigned VEC_W = N_AXIS + N_BLK;
    localparam logic [STALL_CNT_W:0] LP_THR = (STALL_CNT_W+1)'(THRESHOLD);

    // Input capture stage
    logic [N_AXIS-1:0] r_axis;
    logic [N_IDLE-1:0] r_idle;
    logic [N_BLK-1:0]  r_iblk;
    logic              r_clear;

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_axis  <= '0;
            r_idle  <= '0;
            r_iblk  <= '0;
            r_clear <= 1'b0;
        end else begin
            r_axis  <= axis_block_sigs;
            r_idle  <= inst_idle_sigs;
            r_iblk  <= inst_block_sigs;
            r_clear <= clear;
        end
    end

    logic [VEC_W-1:0]       w_vec;
    logic                   w_stall;
    logic                   w_same;
    logic [VEC_W-1:0]       r_snap;
    kmon_state_t            r_state;
    kmon_state_t            w_state_nxt;
    logic [STALL_CNT_W-1:0] w_cnt;
    logic [STALL_CNT_W:0]   w_cnt_plus1;

    logic w_cnt_clr, w_cnt_load, w_cnt_inc;
    logic w_sc_clr, w_sc_load, w_sc_inc;
    logic w_snap_load, w_enter_blk;

    assign w_vec       = {r_iblk, r_axis};
    assign w_stall     = (|w_vec) && !(&r_idle);
    assign w_same      = (w_vec == r_snap);
    assign w_cnt_plus1 = {1'b0, w_cnt} + (STALL_CNT_W+1)'(1);

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_sc_clr    = 1'b0;
        w_sc_load   = 1'b0;
        w_sc_inc    = 1'b0;
        w_snap_load = 1'b0;
        w_enter_blk = 1'b0;
        if (r_clear) begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
            w_sc_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        w_snap_load = 1'b1;
                        w_cnt_load  = 1'b1;
                        w_sc_load   = 1'b1;
                        // A threshold of one is met by the very first stall cycle.
                        if (LP_THR == (STALL_CNT_W+1)'(1)) begin
                            w_state_nxt = BLOCKED;
                            w_enter_blk = 1'b1;
                        end else begin
                            w_state_nxt = WATCH;
                        end
                    end else begin
                        w_cnt_clr = 1'b1;
                        w_sc_clr  = 1'b1;
                    end
                end
                WATCH: begin
                    if (!w_stall) begin
                        w_state_nxt = IDLE;
                        w_cnt_clr   = 1'b1;
                        w_sc_clr    = 1'b1;
                    end else if (!w_same) begin
                        // Pattern moved: treat as progress and restart the run.
                        w_snap_load = 1'b1;
                        w_cnt_load  = 1'b1;
                        w_sc_load   = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                        w_sc_inc  = 1'b1;
                        if (w_cnt_plus1 == LP_THR) begin
                            w_state_nxt = BLOCKED;
                            w_enter_blk = 1'b1;
                        end
                    end
                end
                BLOCKED: begin
                    if (w_stall && w_same) begin
                        w_sc_inc = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_clr   = 1'b1;
                        w_sc_clr    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_clr   = 1'b1;
                    w_sc_clr    = 1'b1;
                end
            endcase
        end
    end

    stall_sat_counter u_cnt (
        .clk     (kernel_monitor_clock),
        .rst_n   (kernel_monitor_reset),
        .i_clr   (w_cnt_clr),
        .i_load1 (w_cnt_load),
        .i_inc   (w_cnt_inc),
        .o_count (w_cnt)
    );

    stall_sat_counter u_stall (
        .clk     (kernel_monitor_clock),
        .rst_n   (kernel_monitor_reset),
        .i_clr   (w_sc_clr),
        .i_load1 (w_sc_load),
        .i_inc   (w_sc_inc),
        .o_count (stall_cycles)
    );

    logic                r_block;
    logic                r_pulse;
    logic [VEC_W-1:0]    r_cause;
    logic [EVT_W-1:0]    r_events;

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_snap   <= '0;
            r_block  <= 1'b0;
            r_pulse  <= 1'b0;
            r_cause  <= '0;
            r_events <= '0;
        end else begin
            r_block <= (w_state_nxt == BLOCKED);
            r_pulse <= w_enter_blk;
            if (r_clear) begin
                r_snap   <= '0;
                r_cause  <= '0;
                r_events <= '0;
            end else begin
                if (w_snap_load) begin
                    r_snap <= w_vec;
                end
                // On entry the live vector equals the snapshot (or becomes it).
                if (w_enter_blk) begin
                    r_cause  <= w_vec;
                    r_events <= r_events + EVT_W'(1);
                end
            end
        end
    end

    assign block        = r_block;
    assign block_pulse  = r_pulse;
    assign block_cause  = r_cause;
    assign block_events = r_events;

endmodule

// File: doc/kernel_stall_detector.md
Name: kernel_stall_detector

Overview:
- Consumes the per-channel AXI-stream blocking flags, sub-instance idle flags and sub-instance blocking flags that the EQ kernel monitor top collects.
- Declares a kernel block only after a stable stall pattern persists for THRESHOLD consecutive cycles. Raw blocking flags toggle every cycle on normal backpressure, so they alone do not count as a block.
- Reports when the block started, its cause vector, its duration and an event count, so the testbench can print diagnostics.

Parameters:
- N_AXIS, 2, number of AXI-stream blocking flags.
- N_IDLE, 3, number of instance idle flags.
- N_BLK, 1, number of instance blocking flags.
- THRESHOLD, 1024, consecutive stable-stall cycles before block asserts; legal range 1..65535.
- EVT_W, 8, width of the block event counter.

Ports:
- kernel_monitor_clock  in  1  sole clock.
- kernel_monitor_reset  in  1  asynchronous, active-low reset.
- axis_block_sigs  in  N_AXIS  1 = stream channel blocked this cycle.
- inst_idle_sigs  in  N_IDLE  1 = instance idle.
- inst_block_sigs  in  N_BLK  1 = instance blocked.
- clear  in  1  synchronous; releases a latched block and zeroes the counters.
- block  out  1  kernel declared blocked.
- block_pulse  out  1  one-cycle strobe on entry to BLOCKED.
- block_cause  out  N_AXIS+N_BLK  snapshot of {inst_block_sigs, axis_block_sigs} at entry to BLOCKED.
- stall_cycles  out  16  length of the current stable stall, saturating at 16'hFFFF.
- block_events  out  EVT_W  number of entries to BLOCKED, wrapping.

Behaviour:
- Reset (kernel_monitor_reset low, async): all outputs 0, state IDLE, counters 0, snapshot register 0.
- Definitions:
  - vec = {inst_block_sigs, axis_block_sigs}.
  - stall_cond = (|vec) && ~(&inst_idle_sigs).
  - An all-idle kernel is never blocked.
- All inputs are registered once before use. All timing below is relative to the registered values, so stall_cond seen at edge k affects outputs at edge k+1.
- State IDLE:
  - If stall_cond: snap <= vec, cnt <= 1, stall_cycles <= 1, go to WATCH.
  - Otherwise stall_cycles <= 0.
- State WATCH:
  - If !stall_cond: go to IDLE, cnt <= 0, stall_cycles <= 0.
  - Else if vec != snap (pattern changed, i.e. progress): snap <= vec, cnt <= 1, stall_cycles <= 1, stay in WATCH.
  - Else cnt++ and stall_cycles++ (saturating). When the incremented cnt == THRESHOLD: go to BLOCKED, block <= 1, block_pulse <= 1 for one cycle, block_cause <= snap, block_events++ (wraps at 2^EVT_W).
- THRESHOLD=1:
  - IDLE goes directly to BLOCKED on the first stall_cond cycle.
  - block asserts 2 edges after stimulus (1 register + 1 state).
- State BLOCKED:
  - stall_cycles keeps incrementing (saturating) while stall_cond holds and vec == snap.
  - If stall_cond drops or vec changes: block <= 0, go to IDLE, stall_cycles <= 0. block_cause and block_events are retained.
- clear:
  - Has highest synchronous priority.
  - Forces IDLE; zeroes block, block_pulse, stall_cycles, block_events and block_cause.
  - A stall still present after clear restarts detection from cnt = 1 on the next cycle.
- Internal counter cnt is 16 bits. block_pulse never asserts two cycles in a row.
- Reset asserted mid-WATCH or mid-BLOCKED: immediate return to reset values, with no block_pulse on release.

Decomposition:
- Shared package kernel_monitor_pkg holds:
  - the state enum {IDLE, WATCH, BLOCKED};
  - constant STALL_CNT_W = 16;
  - the default THRESHOLD.
- One natural sub-module, stall_sat_counter: a 16-bit saturating counter with load-1, increment and clear inputs, used for both cnt and stall_cycles.

Test Plan:
- All sets below use THRESHOLD=4.
- Hold axis_block_sigs=2'b01, inst_idle=3'b000 for 10 cycles -> block rises on the 5th output edge; block_pulse high for exactly 1 cycle; block_cause=3'b001; block_events=1.
- Alternate axis_block_sigs 2'b01 and 2'b10 every 2 cycles for 20 cycles -> block never asserts; stall_cycles never exceeds 2.
- inst_idle_sigs=3'b111 with axis_block_sigs=2'b11 for 10 cycles -> block stays 0, stall_cycles stays 0.
- Enter BLOCKED, then drop axis_block_sigs to 0 -> block falls 2 edges later; block_cause is held; re-stall for 4 cycles -> block_events=2.
- Pulse clear while BLOCKED with the stall still present -> block=0 and block_events=0 next cycle; block re-asserts 4 cycles later with block_events=1.
- Pull kernel_monitor_reset low asynchronously mid-WATCH (cnt=3) -> all outputs 0 immediately; after release with stall held, block needs a full 4 cycles.
